pipelined_adder_nbit: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit combinational full adder.

---
 rtl/adder_pkg.sv | 16 +
 rtl/fulladder_chunk.sv | 26 ++
 rtl/pipelined_adder_nbit.sv | 114 +++++++++++
 tb/tb_pipelined_adder_nbit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared sizing helpers for the pipelined adder family.
// Stage count and legality are derived from WIDTH and CHUNK.
package adder_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultChunk = 4;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  function automatic bit chunking_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width != 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/fulladder_chunk.sv
// Combinational CHUNK-bit ripple adder made of 1-bit full adders.
// Also exposes the carry into the chunk MSB so the top chunk can flag signed overflow.
module fulladder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, valid/ready on both sides with a single global advance.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $fatal(1, "pipelined_adder_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Register level k holds the beat after stage k has added its chunk.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             ovf_q;

  logic             op_v  [STAGES];
  logic             op_c  [STAGES];
  logic [WIDTH-1:0] op_a  [STAGES];
  logic [WIDTH-1:0] op_b  [STAGES];
  logic [WIDTH-1:0] op_s  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];

  logic [CHUNK-1:0] ch_s  [STAGES];
  logic             ch_co [STAGES];
  logic             ch_cm [STAGES];

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage 0 works straight off the ports; b is inverted up front so later stages never see sub.
  always_comb begin
    op_v[0] = in_valid;
    op_c[0] = sub | c_in;
    op_a[0] = a;
    op_b[0] = sub ? ~b : b;
    op_s[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      op_v[k] = v_q[k-1];
      op_c[k] = c_q[k-1];
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_s[k] = s_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_nxt[k]                   = op_s[k];
      s_nxt[k][k*CHUNK +: CHUNK] = ch_s[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fulladder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (op_a[k][k*CHUNK +: CHUNK]),
      .b     (op_b[k][k*CHUNK +: CHUNK]),
      .c_in  (op_c[k]),
      .s     (ch_s[k]),
      .c_out (ch_co[k]),
      .c_msb (ch_cm[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= op_v[k];
        c_q[k] <= ch_co[k];
        s_q[k] <= s_nxt[k];
        a_q[k] <= op_a[k];
        b_q[k] <= op_b[k];
      end
      ovf_q <= ch_cm[STAGES-1] ^ ch_co[STAGES-1];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Directed bench for pipelined_adder_nbit in 16/4, 8/8 and 32/4 configurations.
module tb_pipelined_adder_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv32, ir32, ci32, sb32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;

  pipelined_adder_nbit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .c_in(ci16),
    .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16), .ovf(of16)
  );

  pipelined_adder_nbit #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .c_in(ci8),
    .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .c_out(co8), .ovf(of8)
  );

  pipelined_adder_nbit #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .c_in(ci32),
    .sub(sb32), .out_valid(ov32), .out_ready(or32), .sum(s32), .c_out(co32), .ovf(of32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ovf, c_out, sum}
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] full;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sb ? 1'b1 : ci)};
    return {(a[15] == bb[15]) && (full[15] != a[15]), full};
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
    return {(a[31] == bb[31]) && (full[31] != a[31]), full};
  endfunction

  task automatic beat16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic eco, input logic eof);
    a16 = a; b16 = b; ci16 = ci; sb16 = sb; iv16 = 1'b1;
    tick();
    iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, 64'(ov16), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(ov16), 64'd1);
    chk({tag, "_sum"}, 64'(s16), 64'(es));
    chk({tag, "_cout"}, 64'(co16), 64'(eco));
    chk({tag, "_ovf"}, 64'(of16), 64'(eof));
    tick();
    chk({tag, "_drop"}, 64'(ov16), 64'd0);
  endtask

  logic [17:0] exp_bb [8];
  logic [17:0] q [$];
  logic [33:0] exp32 [10];

  initial begin
    int next;
    int delivered;
    int seen;
    rst_n = 1'b0;
    iv16 = 0; a16 = '0; b16 = '0; ci16 = 0; sb16 = 0; or16 = 1;
    iv8 = 0;  a8 = '0;  b8 = '0;  ci8 = 0;  sb8 = 0;  or8 = 1;
    iv32 = 0; a32 = '0; b32 = '0; ci32 = 0; sb32 = 0; or32 = 1;

    #3;
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_sum", 64'(s16), 64'd0);
    chk("rst_cout", 64'(co16), 64'd0);
    chk("rst_ovf", 64'(of16), 64'd0);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    chk("rst_out_valid8", 64'(ov8), 64'd0);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    beat16("add_cin", 16'h0000, 16'hFFFE, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    beat16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    beat16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    beat16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    beat16("sub_neg", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Eight back-to-back beats: results must appear on cycles 4..11 in order.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        a16 = 16'(c * 16'h1357); b16 = 16'(16'hF00F + c); ci16 = c[0]; sb16 = 1'b0; iv16 = 1'b1;
        exp_bb[c] = ref16(a16, b16, ci16, 1'b0);
      end else begin
        iv16 = 1'b0;
      end
      tick();
      chk("bb_in_ready", 64'(ir16), 64'd1);
      if (c >= 3 && c < 11) begin
        chk("bb_valid", 64'(ov16), 64'd1);
        chk("bb_result", 64'({co16, s16}), 64'(exp_bb[c-3][16:0]));
      end else begin
        chk("bb_idle", 64'(ov16), 64'd0);
      end
    end
    iv16 = 1'b0;

    // Full pipeline, downstream stalls for three cycles.
    next = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 30 && delivered < 6; cyc++) begin
      iv16 = (next < 6);
      a16  = 16'(16'hA000 + next * 16'h0123);
      b16  = 16'(16'h1F0F + next * 16'h0777);
      ci16 = next[0];
      sb16 = next[1];
      or16 = (cyc < 4 || cyc > 6);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        chk("stall_in_ready", 64'(ir16), 64'd0);
        chk("stall_valid", 64'(ov16), 64'd1);
        chk("stall_frozen", 64'({of16, co16, s16}), 64'(q[0]));
      end
      if (ov16 && or16) begin
        chk("stall_result", 64'({of16, co16, s16}), 64'(q.pop_front()));
        delivered++;
      end
      if (iv16 && ir16) begin
        q.push_back(ref16(a16, b16, ci16, sb16));
        next++;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_delivered", 64'(delivered), 64'd6);
    chk("stall_leftover", 64'(q.size()), 64'd0);
    iv16 = 1'b0;
    or16 = 1'b1;

    // Single-stage configuration: latency 1.
    a8 = 8'h7F; b8 = 8'h01; ci8 = 0; sb8 = 0; iv8 = 1;
    tick();
    iv8 = 0;
    chk("w8_add_valid", 64'(ov8), 64'd1);
    chk("w8_add_res", 64'({of8, co8, s8}), 64'({1'b1, 1'b0, 8'h80}));
    a8 = 8'h00; b8 = 8'h01; ci8 = 1; sb8 = 1; iv8 = 1;
    tick();
    iv8 = 0;
    chk("w8_sub_res", 64'({of8, co8, s8}), 64'({1'b0, 1'b0, 8'hFF}));
    tick();
    chk("w8_drop", 64'(ov8), 64'd0);

    // Reset with three beats in flight (and one in the single-stage instance).
    for (int i = 0; i < 3; i++) begin
      a16 = 16'(16'h1000 * (i + 1)); b16 = 16'h0101; ci16 = 0; sb16 = 0; iv16 = 1'b1;
      iv8 = (i == 2); a8 = 8'h12; b8 = 8'h34; ci8 = 0; sb8 = 0;
      tick();
    end
    iv16 = 1'b0;
    iv8  = 1'b0;
    chk("rstmid_pre16", 64'(ov16), 64'd0);
    chk("rstmid_pre8", 64'(ov8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid16", 64'(ov16), 64'd0);
    chk("rstmid_sum16", 64'(s16), 64'd0);
    chk("rstmid_valid8", 64'(ov8), 64'd0);
    chk("rstmid_sum8", 64'(s8), 64'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov16 || ov8) seen++;
    end
    chk("rstmid_no_emit", 64'(seen), 64'd0);

    // 32-bit random beats against the reference model.
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        a32 = $urandom; b32 = $urandom;
        ci32 = 1'($urandom_range(0, 1)); sb32 = 1'($urandom_range(0, 1)); iv32 = 1'b1;
        exp32[c] = ref32(a32, b32, ci32, sb32);
      end else begin
        iv32 = 1'b0;
      end
      tick();
      if (c >= 7 && c < 17) begin
        chk("w32_valid", 64'(ov32), 64'd1);
        chk("w32_result", 64'({of32, co32, s32}), 64'(exp32[c-7]));
      end else begin
        chk("w32_idle", 64'(ov32), 64'd0);
      end
    end
    iv32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) chk("w32_tail_valid", 64'(ov32), 64'd1);
      else       chk("w32_tail_idle", 64'(ov32), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
